// File: rtl/half_layer2_sequencer.sv
// half_layer2_sequencer: control FSM for the half-precision output layer.
// Loads W2/b2 from a 1-cycle-latency parameter memory, streams a captured
// hidden vector into the layer, waits for the softmax vector and scans it
// for the winning class.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   cmd_load, cmd_predict          command pulses (accepted in IDLE only)
//   x_vec                          hidden vector, sampled on accepted predict
//   mem_rd_en, mem_addr, mem_rdata parameter-memory read port
//   load_W2, load_b2               to layer: parameter beat strobes
//   neuron_data_out                to layer: mem_rdata passed straight through
//   layer_in_valid, x_out          to layer: x beat stream
//   layer_out_valid, layer_y       from layer: softmax done pulse and vector
//   busy, weights_loaded           status
//   result_valid, result_class,
//   result_prob, err               result pulse/values, error pulse
module half_layer2_sequencer #(
    parameter int unsigned LAYER2_NEURONS = 10,
    parameter int unsigned OUTPUT_NODES   = 10,
    parameter int unsigned MULTS          = 1,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT        = 4096
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               cmd_load,
    input  logic                               cmd_predict,
    input  logic [16*LAYER2_NEURONS-1:0]       x_vec,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic [16*MULTS-1:0]                mem_rdata,
    output logic                               load_W2,
    output logic                               load_b2,
    output logic                               layer_in_valid,
    output logic [16*MULTS-1:0]                neuron_data_out,
    output logic [16*MULTS-1:0]                x_out,
    input  logic                               layer_out_valid,
    input  logic [16*OUTPUT_NODES-1:0]         layer_y,
    output logic                               busy,
    output logic                               weights_loaded,
    output logic                               result_valid,
    output logic [$clog2(OUTPUT_NODES)-1:0]    result_class,
    output logic [15:0]                        result_prob,
    output logic                               err
);

    localparam int unsigned X_BEATS = LAYER2_NEURONS / MULTS;
    localparam int unsigned W_BEATS = OUTPUT_NODES * X_BEATS;
    localparam int unsigned LANE_W  = 16 * MULTS;
    localparam int unsigned XB_W    = (X_BEATS > 1) ? $clog2(X_BEATS) : 1;
    localparam int unsigned CLS_W   = $clog2(OUTPUT_NODES);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_B, LOAD_END, STREAM_X, WAIT_Y, ARGMAX, DONE
    } state_t;

    state_t                       state_q, state_d;
    logic                         mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
    logic                         load_w2_q, load_w2_d;
    logic                         load_b2_q, load_b2_d;
    logic                         layer_in_valid_q, layer_in_valid_d;
    logic [LANE_W-1:0]            x_out_q, x_out_d;
    logic [16*LAYER2_NEURONS-1:0] x_reg_q, x_reg_d;
    logic [XB_W-1:0]              beat_q, beat_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [16*OUTPUT_NODES-1:0]   y_reg_q, y_reg_d;
    logic [CLS_W-1:0]             idx_q, idx_d;
    logic [CLS_W-1:0]             best_idx_q, best_idx_d;
    logic [15:0]                  best_val_q, best_val_d;
    logic                         busy_q, busy_d;
    logic                         weights_loaded_q, weights_loaded_d;
    logic                         result_valid_q, result_valid_d;
    logic [CLS_W-1:0]             result_class_q, result_class_d;
    logic [15:0]                  result_prob_q, result_prob_d;
    logic                         err_q, err_d;
    logic [15:0]                  cand;

    // Ordering on bits[14:0]; NaN loses to everything, strict greater-than keeps ties on the lower index.
    function automatic logic ranks_above(input logic [15:0] a, input logic [15:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        return !a_nan && (b_nan || (a[14:0] > b[14:0]));
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d          = state_q;
        mem_addr_d       = '0;
        x_reg_d          = x_reg_q;
        beat_d           = '0;
        tmo_d            = '0;
        y_reg_d          = y_reg_q;
        idx_d            = '0;
        best_idx_d       = best_idx_q;
        best_val_d       = best_val_q;
        weights_loaded_d = weights_loaded_q;
        result_valid_d   = 1'b0;
        result_class_d   = result_class_q;
        result_prob_d    = result_prob_q;
        err_d            = 1'b0;
        cand             = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_load) begin
                    state_d          = LOAD_W;
                    weights_loaded_d = 1'b0;
                end else if (cmd_predict) begin
                    if (weights_loaded_q) begin
                        x_reg_d = x_vec;
                        state_d = STREAM_X;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (mem_addr_q == ADDR_W'(W_BEATS - 1)) begin
                    state_d    = LOAD_B;
                    mem_addr_d = ADDR_W'(W_BEATS);
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            LOAD_B: begin
                if (mem_addr_q == ADDR_W'(W_BEATS + OUTPUT_NODES - 1)) begin
                    state_d = LOAD_END;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end
            end
            LOAD_END: begin
                weights_loaded_d = 1'b1;
                state_d          = IDLE;
            end
            STREAM_X: begin
                if (beat_q == XB_W'(X_BEATS - 1)) begin
                    state_d = WAIT_Y;
                end else begin
                    beat_d = beat_q + XB_W'(1);
                end
            end
            WAIT_Y: begin
                if (layer_out_valid) begin
                    y_reg_d = layer_y;
                    state_d = ARGMAX;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ARGMAX: begin
                cand = y_reg_q[16*32'(idx_q) +: 16];
                if ((idx_q == '0) || ranks_above(cand, best_val_q)) begin
                    best_idx_d = idx_q;
                    best_val_d = cand;
                end
                if (idx_q == CLS_W'(OUTPUT_NODES - 1)) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    result_class_d = best_idx_d;
                    result_prob_d  = best_val_d;
                end else begin
                    idx_d = idx_q + CLS_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read strobe/address and x beat registered with the state they belong to.
        mem_rd_en_d      = (state_d == LOAD_W) || (state_d == LOAD_B);
        // Load strobes trail the read phase by one cycle to line up with mem_rdata.
        load_w2_d        = (state_q == LOAD_W);
        load_b2_d        = (state_q == LOAD_B);
        layer_in_valid_d = (state_d == STREAM_X);
        x_out_d          = layer_in_valid_d ? x_reg_d[LANE_W*32'(beat_d) +: LANE_W] : '0;
        busy_d           = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= IDLE;
            mem_rd_en_q      <= 1'b0;
            mem_addr_q       <= '0;
            load_w2_q        <= 1'b0;
            load_b2_q        <= 1'b0;
            layer_in_valid_q <= 1'b0;
            x_out_q          <= '0;
            x_reg_q          <= '0;
            beat_q           <= '0;
            tmo_q            <= '0;
            y_reg_q          <= '0;
            idx_q            <= '0;
            best_idx_q       <= '0;
            best_val_q       <= '0;
            busy_q           <= 1'b0;
            weights_loaded_q <= 1'b0;
            result_valid_q   <= 1'b0;
            result_class_q   <= '0;
            result_prob_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_rd_en_q      <= mem_rd_en_d;
            mem_addr_q       <= mem_addr_d;
            load_w2_q        <= load_w2_d;
            load_b2_q        <= load_b2_d;
            layer_in_valid_q <= layer_in_valid_d;
            x_out_q          <= x_out_d;
            x_reg_q          <= x_reg_d;
            beat_q           <= beat_d;
            tmo_q            <= tmo_d;
            y_reg_q          <= y_reg_d;
            idx_q            <= idx_d;
            best_idx_q       <= best_idx_d;
            best_val_q       <= best_val_d;
            busy_q           <= busy_d;
            weights_loaded_q <= weights_loaded_d;
            result_valid_q   <= result_valid_d;
            result_class_q   <= result_class_d;
            result_prob_q    <= result_prob_d;
            err_q            <= err_d;
        end
    end

    assign mem_rd_en       = mem_rd_en_q;
    assign mem_addr        = mem_addr_q;
    assign load_W2         = load_w2_q;
    assign load_b2         = load_b2_q;
    assign layer_in_valid  = layer_in_valid_q;
    assign neuron_data_out = mem_rdata;
    assign x_out           = x_out_q;
    assign busy            = busy_q;
    assign weights_loaded  = weights_loaded_q;
    assign result_valid    = result_valid_q;
    assign result_class    = result_class_q;
    assign result_prob     = result_prob_q;
    assign err             = err_q;

endmodule
